mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port between the fetch stage (instruction reads) and the memory stage (load/store).
- Sits between the pipeline controller/datapath and the synchronous memory block.
- Provides a multi-cycle read/write transaction engine and a busy indication that the controller uses to hold PCwrite/IRload/IR3load/IR4load.
- One transaction is in flight at a time.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width
MEM_LATENCY, 1, cycles from the mem_re cycle to valid mem_rdata; legal range 1..15

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch address
if_grant  out  1  fetch request accepted this cycle
if_valid  out  1  one-cycle pulse, fetch data ready
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data-stage request
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_grant  out  1  data request accepted this cycle
d_valid  out  1  one-cycle pulse, load data ready / store complete
d_rdata  out  DATA_W  load data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_re  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data
busy  out  1  transaction in progress, high when state != IDLE

Behaviour:
- Interface: one clock named clock; reset named reset, synchronous and active-high.
- Reset values: state=IDLE, wait counter=0, owner=fetch. All strobes, grants, valids and busy are 0. mem_addr, mem_wdata, if_rdata and d_rdata are 0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any request is present, assert the winner's grant combinationally in this cycle.
  - On the clock edge, latch owner, address, wdata and we into holding registers; go to ISSUE.
  - With no request, stay in IDLE.
  - Grants are only ever asserted in IDLE, and at most one grant per cycle.
- Arbitration: fixed priority, data over fetch, because the data stage holds the older instruction. The loser keeps its request asserted and is granted on the next IDLE cycle.
- ISSUE:
  - Exactly one cycle.
  - mem_addr/mem_wdata are driven from the holding registers.
  - mem_re=1 if the latched we=0; mem_we=1 if we=1.
  - Load the counter with MEM_LATENCY; go to WAIT.
- WAIT:
  - Strobes are 0; mem_addr is held.
  - The counter decrements each cycle.
  - In the cycle where the counter equals 1, sample mem_rdata into the owner's rdata register on reads only, then go to RESP.
- RESP:
  - Owner's valid=1 for exactly one cycle; then go to IDLE.
  - A store pulses d_valid and leaves d_rdata unchanged.
- Latency: grant in cycle T, strobe in T+1, valid in T+2+MEM_LATENCY. Back-to-back grants are separated by 3+MEM_LATENCY cycles.
- if_rdata and d_rdata hold their last captured value until the next read completion for that port.
- A request deasserted after its grant does not cancel the transaction; it completes normally.
- Requester inputs are ignored outside the IDLE grant cycle; the holding registers are authoritative.
- Reset in any state:
  - Return to IDLE next cycle.
  - A pending valid pulse is dropped.
  - No strobe is issued in the cycle after reset is asserted.
  - The rdata registers are cleared.
- Out-of-range MEM_LATENCY is a configuration error and is not checked in RTL.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last_owner register is reset to fetch. On a simultaneous request, the port that did not win the previous grant wins; last_owner updates on every grant.
- Undefined: fixed data-over-fetch priority; no last_owner register is present.

Test Plan:
- MEM_LATENCY=1, mem[0x10]=0xA5, if_req with if_addr=0x10 in cycle 0 -> if_grant in cycle 0; mem_re=1 and mem_addr=0x10 in cycle 1; if_valid=1 and if_rdata=0xA5 in cycle 3; busy high in cycles 1-3.
- Simultaneous if_req(0x10) and d_req load(0x20, mem=0x3C) -> d_grant first, d_valid with d_rdata=0x3C in cycle 3. if_grant in cycle 4, then if_valid in cycle 7 with 0xA5.
- Store: d_req, d_we=1, d_addr=0x40, d_wdata=0x7E in cycle 0 -> mem_we=1, mem_addr=0x40, mem_wdata=0x7E in cycle 1. d_valid in cycle 3; d_rdata unchanged; mem_re never asserted.
- MEM_LATENCY=3, fetch 0x10 -> mem_re in cycle 1, rdata sampled in cycle 4, if_valid in cycle 5. d_req raised in cycle 2 -> d_grant not before cycle 6.
- Reset asserted in a WAIT cycle -> next cycle IDLE, busy=0, no if_valid pulse, if_rdata=0; a subsequent fetch completes with normal timing.
- With MEM_PORT_ARB_RR_EN, both requests held continuously -> grants alternate data, fetch, data, fetch.
- Without MEM_PORT_ARB_RR_EN, both requests held continuously -> data wins every IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer for fetch and data stages: IDLE -> ISSUE -> WAIT -> RESP.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_port_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_grant,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick_data;
    logic              grant_any;

`ifdef MEM_PORT_ARB_RR_EN
    logic              last_q, last_d;

    // On a tie the port that lost the previous grant goes first (last_q=1 means data won last).
    assign pick_data = d_req && (!if_req || !last_q);

    always_comb begin
        last_d = last_q;
        if (grant_any) begin
            last_d = pick_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // The data stage holds the older instruction, so it always wins a tie.
    assign pick_data = d_req;
`endif

    assign grant_any = (state_q == S_IDLE) && !reset && (if_req || d_req);
    assign d_grant   = grant_any && pick_data;
    assign if_grant  = grant_any && !pick_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    owner_d = pick_data;
                    addr_d  = pick_data ? d_addr : if_addr;
                    wdata_d = pick_data ? d_wdata : '0;
                    we_d    = pick_data && d_we;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_re    = (state_q == S_ISSUE) && !we_q;
    assign mem_we    = (state_q == S_ISSUE) && we_q;
    assign busy      = (state_q != S_IDLE);
    assign if_valid  = (state_q == S_RESP) && !owner_q;
    assign d_valid   = (state_q == S_RESP) && owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3,
// each with its own small synchronous memory model; both share the requester inputs.
module tb_mem_port_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       if_req = 1'b0;
    logic [7:0] if_addr = 8'h00;
    logic       d_req = 1'b0;
    logic       d_we = 1'b0;
    logic [7:0] d_addr = 8'h00;
    logic [7:0] d_wdata = 8'h00;

    logic       if_grant1, if_valid1, d_grant1, d_valid1, mem_re1, mem_we1, busy1;
    logic [7:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic       if_grant3, if_valid3, d_grant3, d_valid3, mem_re3, mem_we3, busy3;
    logic [7:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant1), .if_valid(if_valid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant1), .d_valid(d_valid1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_re(mem_re1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant3), .if_valid(if_valid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant3), .d_valid(d_valid3), .d_rdata(d_rdata3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_re(mem_re3), .mem_we(mem_we3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    // Memory models: read data is valid only in the cycle MEM_LATENCY after the strobe, garbage otherwise.
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] pendAddr1, pendAddr3;
    logic [3:0] pend1, pend3;

    always @(posedge clock) begin
        if (reset) begin
            mem1[8'h10] <= 8'hA5;
            mem1[8'h20] <= 8'h3C;
            pend1 <= 4'd0;
        end else begin
            if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
            if (mem_re1) begin
                pendAddr1 <= mem_addr1;
                pend1 <= 4'd1;
            end else if (pend1 != 4'd0) begin
                pend1 <= pend1 - 4'd1;
            end
        end
    end
    assign mem_rdata1 = (pend1 == 4'd1) ? mem1[pendAddr1] : 8'hEE;

    always @(posedge clock) begin
        if (reset) begin
            mem3[8'h10] <= 8'hA5;
            mem3[8'h20] <= 8'h3C;
            pend3 <= 4'd0;
        end else begin
            if (mem_we3) mem3[mem_addr3] <= mem_wdata3;
            if (mem_re3) begin
                pendAddr3 <= mem_addr3;
                pend3 <= 4'd3;
            end else if (pend3 != 4'd0) begin
                pend3 <= pend3 - 4'd1;
            end
        end
    end
    assign mem_rdata3 = (pend3 == 4'd1) ? mem3[pendAddr3] : 8'hEE;

    // ctl bits: {if_grant, d_grant, mem_re, mem_we, busy, if_valid, d_valid}
    typedef struct {
        logic       ifReq;
        logic [7:0] ifAddr;
        logic       dReq;
        logic       dWe;
        logic [7:0] dAddr;
        logic [7:0] dWdata;
        logic [6:0] expCtl;
        logic [7:0] expIfRdata;
        logic [7:0] expDRdata;
        logic       chkMem;
        logic [7:0] expMemAddr;
        logic [7:0] expMemWdata;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    task automatic applyStimulus(input logic ir, input logic [7:0] ia, input logic dr,
                                 input logic dw, input logic [7:0] da, input logic [7:0] dd);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state of both instances
        reset = 1'b1;
        nextCycle();
        @(negedge clock);
        checkOutput("reset dut1 ctl/rdata",
                    {if_grant1, d_grant1, mem_re1, mem_we1, busy1, if_valid1, d_valid1, if_rdata1, d_rdata1}, 32'h0);
        checkOutput("reset dut1 mem_addr/wdata", {mem_addr1, mem_wdata1}, 32'h0);
        checkOutput("reset dut3 ctl/rdata",
                    {if_grant3, d_grant3, mem_re3, mem_we3, busy3, if_valid3, d_valid3, if_rdata3, d_rdata3}, 32'h0);

        vecs[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 7'b1000000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0010100, 8'h00, 8'h00, 1'b1, 8'h10, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000100, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000110, 8'hA5, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00, 7'b0100000, 8'hA5, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0010100, 8'hA5, 8'h00, 1'b1, 8'h20, 8'h00};
        vecs[6]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000100, 8'hA5, 8'h00, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000101, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 7'b1000000, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0010100, 8'hA5, 8'h3C, 1'b1, 8'h10, 8'h00};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000100, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000110, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 8'h7E, 7'b0100000, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0001100, 8'hA5, 8'h3C, 1'b1, 8'h40, 8'h7E};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000100, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000101, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 7'b0100000, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0010100, 8'hA5, 8'h3C, 1'b1, 8'h40, 8'h00};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000100, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000101, 8'hA5, 8'h7E, 1'b0, 8'h00, 8'h00};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000000, 8'hA5, 8'h7E, 1'b0, 8'h00, 8'h00};

        // Fetch, contended load/fetch, store, then load-back of the stored byte (latency 1)
        doReset();
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].ifReq, vecs[i].ifAddr, vecs[i].dReq, vecs[i].dWe, vecs[i].dAddr, vecs[i].dWdata);
            @(negedge clock);
            checkOutput($sformatf("vec%0d ctl/rdata", i),
                        {if_grant1, d_grant1, mem_re1, mem_we1, busy1, if_valid1, d_valid1, if_rdata1, d_rdata1},
                        {vecs[i].expCtl, vecs[i].expIfRdata, vecs[i].expDRdata});
            if (vecs[i].chkMem) begin
                checkOutput($sformatf("vec%0d mem_addr/wdata", i), {mem_addr1, mem_wdata1},
                            {vecs[i].expMemAddr, vecs[i].expMemWdata});
            end
            nextCycle();
        end

        // Both requests held continuously: grant every fourth cycle, winner per arbitration mode
        doReset();
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00);
        for (int k = 0; k < 16; k++) begin
            logic [1:0] expG;
            expG = 2'b00;
            if (k % 4 == 0) begin
`ifdef MEM_PORT_ARB_RR_EN
                expG = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
`else
                expG = 2'b01;
`endif
            end
            @(negedge clock);
            checkOutput($sformatf("contend cyc%0d {if_grant,d_grant}", k), {if_grant1, d_grant1}, expG);
            nextCycle();
        end

        // Latency 3: fetch then a data request raised while busy
        doReset();
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("lat3 c0 if_grant", if_grant3, 1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("lat3 c1 mem_re/addr", {mem_re3, mem_addr3}, {1'b1, 8'h10});
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clock);
            checkOutput($sformatf("lat3 c%0d d_grant/busy/if_valid", c), {d_grant3, busy3, if_valid3}, 3'b010);
            nextCycle();
        end
        @(negedge clock);
        checkOutput("lat3 c5 if_valid/if_rdata/d_grant", {if_valid3, if_rdata3, d_grant3}, {1'b1, 8'hA5, 1'b0});
        nextCycle();
        @(negedge clock);
        checkOutput("lat3 c6 d_grant/busy", {d_grant3, busy3}, 2'b10);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) nextCycle();
        @(negedge clock);
        checkOutput("lat3 c11 d_valid/d_rdata", {d_valid3, d_rdata3}, {1'b1, 8'h3C});
        nextCycle();

        // Reset during WAIT drops the pending response and clears read data
        doReset();
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        nextCycle();
        @(negedge clock);
        checkOutput("rst c3 if_valid/if_rdata", {if_valid1, if_rdata1}, {1'b1, 8'hA5});
        nextCycle();
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        nextCycle();
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst c6 busy in WAIT", busy1, 1);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("rst c7 busy/if_valid/mem_re/if_grant/if_rdata",
                    {busy1, if_valid1, mem_re1, if_grant1, if_rdata1}, {4'b0001, 8'h00});
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        checkOutput("rst c8 mem_re/if_valid", {mem_re1, if_valid1}, 2'b10);
        nextCycle();
        nextCycle();
        @(negedge clock);
        checkOutput("rst c10 if_valid/if_rdata", {if_valid1, if_rdata1}, {1'b1, 8'hA5});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
